// File: rtl/llac_core_scheduler.sv
// llac_core_scheduler: per-sample dispatcher for the audio core array.
// Owns core lifecycles, start/done handshakes and the watchdog.
module llac_core_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         clk_100mhz,
    input  logic                         resetn,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [NUM_CORES-1:0]         core_pause,
    input  logic [NUM_CORES-1:0]         core_stop,
    input  logic [NUM_CORES-1:0]         core_resume,
    input  logic [NUM_CORES-1:0]         core_done,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES-1:0]         core_status,
    output logic [NUM_CORES-1:0]         core_interrupt,
    output logic [$clog2(NUM_CORES)-1:0] active_core,
    output logic                         frame_done,
    output logic                         frame_timeout,
    output logic                         sample_dropped,
    output logic [CNT_WIDTH-1:0]         overrun_count
);

    localparam int IW = $clog2(NUM_CORES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_CORES - 1);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CORES-1:0] ONE      = NUM_CORES'(1);

    typedef enum logic [1:0] {
        L_IDLE,
        L_ACTIVE,
        L_PAUSED,
        L_STOPPED
    } life_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    life_t                life [NUM_CORES];
    state_t               state;
    logic [IW-1:0]        idx;
    logic [NUM_CORES-1:0] mask;
    logic [TW-1:0]        timer;

    logic                 in_wait;
    logic                 cur_done;
    logic                 cur_stop;
    logic                 tmo_reached;
    logic                 tmo_hit;
    logic                 wait_end;
    logic [NUM_CORES-1:0] idx_onehot;
    logic [NUM_CORES-1:0] tmo_vec;
    logic                 drop;

    assign sample_ready = (state == S_IDLE);
    assign active_core  = idx;

    assign in_wait     = (state == S_WAIT);
    assign cur_done    = core_done[idx];
    assign cur_stop    = core_stop[idx];
    assign tmo_reached = (timer == TMO_LAST);
    assign idx_onehot  = ONE << idx;

    // A done (or a stop of the dispatched core) beats a same-cycle expiry
    assign tmo_hit  = in_wait && tmo_reached && !cur_done && !cur_stop;
    assign wait_end = in_wait && (cur_done || cur_stop || tmo_reached);
    assign tmo_vec  = tmo_hit ? idx_onehot : '0;
    assign drop     = sample_valid && (state != S_IDLE);

    // Status is a pure decode of the lifecycle flops
    always_comb begin
        core_status = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_status[i] = (life[i] == L_ACTIVE);
        end
    end

    // Lifecycle update: stop/watchdog > pause > resume
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                life[i] <= L_IDLE;
            end
            core_interrupt <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_stop[i] || tmo_vec[i]) begin
                    life[i]           <= L_STOPPED;
                    core_interrupt[i] <= 1'b1;
                end else if (core_pause[i]) begin
                    if (life[i] == L_ACTIVE) begin
                        life[i] <= L_PAUSED;
                    end
                end else if (core_resume[i]) begin
                    if (life[i] != L_ACTIVE) begin
                        life[i]           <= L_ACTIVE;
                        core_interrupt[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Dispatcher: scan the snapshot mask, start and wait on one core at a time
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            idx           <= '0;
            mask          <= '0;
            timer         <= '0;
            core_start    <= '0;
            frame_done    <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            core_start    <= '0;
            frame_done    <= 1'b0;
            frame_timeout <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        mask  <= core_status;
                        idx   <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (mask[idx]) begin
                        state <= S_START;
                    end else if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_START: begin
                    core_start <= idx_onehot;
                    timer      <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (wait_end) begin
                        frame_timeout <= tmo_hit;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Samples arriving while busy are dropped and counted (saturating)
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            sample_dropped <= 1'b0;
            overrun_count  <= '0;
        end else begin
            sample_dropped <= drop;
            if (drop && (overrun_count != '1)) begin
                overrun_count <= overrun_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_llac_core_scheduler.sv
// tb_llac_core_scheduler: scoreboard bench for the core scheduler.
// Expected start pulses are queued at sample time and popped on output.
module tb_llac_core_scheduler;

    logic        clk_100mhz = 1'b0;
    logic        resetn = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [3:0]  core_pause = '0;
    logic [3:0]  core_stop = '0;
    logic [3:0]  core_resume = '0;
    logic [3:0]  core_done = '0;
    logic [3:0]  core_start;
    logic [3:0]  core_status;
    logic [3:0]  core_interrupt;
    logic [1:0]  active_core;
    logic        frame_done;
    logic        frame_timeout;
    logic        sample_dropped;
    logic [15:0] overrun_count;

    llac_core_scheduler #(
        .NUM_CORES(4),
        .TIMEOUT_CYCLES(2048),
        .CNT_WIDTH(16)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .resetn(resetn),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .core_pause(core_pause),
        .core_stop(core_stop),
        .core_resume(core_resume),
        .core_done(core_done),
        .core_start(core_start),
        .core_status(core_status),
        .core_interrupt(core_interrupt),
        .active_core(active_core),
        .frame_done(frame_done),
        .frame_timeout(frame_timeout),
        .sample_dropped(sample_dropped),
        .overrun_count(overrun_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    bit   sb_en = 1'b1;

    int cyc = 0;
    int t_acc = 0;
    int start_cnt = 0;
    int first_start = -1;
    int start_cyc [4];
    int fd_cnt = 0;
    int fd_cyc = 0;
    int to_cnt = 0;
    int to_cyc = 0;
    int drop_cnt = 0;

    logic [3:0] resp_en = '0;
    int resp_dly = 3;
    int cnt [4];

    always @(posedge clk_100mhz) cyc++;

    // Core model: answer done resp_dly cycles after each start
    always @(negedge clk_100mhz) begin
        core_done = '0;
        for (int i = 0; i < 4; i++) begin
            if (!resetn) begin
                cnt[i] = 0;
            end else begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) core_done[i] = 1'b1;
                end
                if (core_start[i] && resp_en[i]) cnt[i] = resp_dly;
            end
        end
    end

    // Output monitor and scoreboard pop
    always @(negedge clk_100mhz) begin
        logic [3:0] e;
        if (resetn) begin
            if (core_start != 4'b0000) begin
                start_cnt++;
                if (first_start < 0) first_start = cyc;
                for (int i = 0; i < 4; i++)
                    if (core_start[i]) start_cyc[i] = cyc;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL start_unexpected got %b want none",
                                 core_start);
                    end else begin
                        e = exp_q.pop_front();
                        if (core_start !== e) begin
                            errors++;
                            $display("FAIL start_order got %b want %b",
                                     core_start, e);
                        end
                    end
                end
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (frame_timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (sample_dropped) drop_cnt++;
        end
    end

    task automatic apply_reset();
        resetn       = 1'b0;
        sample_valid = 1'b0;
        core_pause   = '0;
        core_stop    = '0;
        core_resume  = '0;
        resp_en      = '0;
        resp_dly     = 3;
        exp_q.delete();
        repeat (3) @(negedge clk_100mhz);
        resetn = 1'b1;
        @(negedge clk_100mhz);
    endtask

    task automatic strobe(input logic [3:0] p, input logic [3:0] s,
                          input logic [3:0] r);
        @(negedge clk_100mhz);
        core_pause  = p;
        core_stop   = s;
        core_resume = r;
        @(negedge clk_100mhz);
        core_pause  = '0;
        core_stop   = '0;
        core_resume = '0;
    endtask

    task automatic send_sample(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) exp_q.push_back(4'b0001 << i);
        @(negedge clk_100mhz);
        sample_valid = 1'b1;
        t_acc = cyc + 1;
        @(negedge clk_100mhz);
        sample_valid = 1'b0;
    endtask

    task automatic wait_frame(input int bound);
        int n0;
        int k;
        n0 = fd_cnt;
        k = 0;
        while (fd_cnt == n0 && k < bound) begin
            @(negedge clk_100mhz);
            #1;
            k++;
        end
        checks++;
        if (fd_cnt == n0) begin
            errors++;
            $display("FAIL frame_wait got no frame_done want one in %0d",
                     bound);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b want 1", sample_ready);
        end
        if (core_status !== 4'b0000) begin
            errors++; $display("FAIL rst_status got %b want 0000", core_status);
        end
        if (core_interrupt !== 4'b0000) begin
            errors++; $display("FAIL rst_irq got %b want 0000", core_interrupt);
        end
        if (overrun_count !== 16'h0000) begin
            errors++; $display("FAIL rst_ovr got %h want 0", overrun_count);
        end
        if (active_core !== 2'd0) begin
            errors++; $display("FAIL rst_active got %0d want 0", active_core);
        end
        if (core_start !== 4'b0000) begin
            errors++; $display("FAIL rst_start got %b want 0000", core_start);
        end
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL rst_fd got %b want 0", frame_done);
        end
        if (sample_dropped !== 1'b0) begin
            errors++; $display("FAIL rst_drop got %b want 0", sample_dropped);
        end
    endtask

    task automatic test_basic();
        int fd0;
        int d0;
        strobe(4'b0000, 4'b0000, 4'b0101);
        checks++;
        if (core_status !== 4'b0101) begin
            errors++; $display("FAIL basic_resume got %b want 0101", core_status);
        end
        resp_en     = 4'b1111;
        resp_dly    = 3;
        first_start = -1;
        fd0 = fd_cnt;
        d0  = drop_cnt;
        send_sample(4'b0101);
        repeat (2) @(negedge clk_100mhz);
        sample_valid = 1'b1;
        @(negedge clk_100mhz);
        sample_valid = 1'b0;
        wait_frame(100);
        checks += 9;
        if (first_start - t_acc !== 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want 2", first_start - t_acc);
        end
        if (fd_cnt - fd0 !== 1) begin
            errors++; $display("FAIL basic_fd got %0d want 1", fd_cnt - fd0);
        end
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL basic_q got %0d want 0", exp_q.size());
        end
        if (overrun_count !== 16'd1) begin
            errors++; $display("FAIL basic_ovr got %0d want 1", overrun_count);
        end
        if (drop_cnt - d0 !== 1) begin
            errors++; $display("FAIL basic_drop got %0d want 1", drop_cnt - d0);
        end
        if (core_status !== 4'b0101) begin
            errors++; $display("FAIL basic_status got %b want 0101", core_status);
        end
        if (core_interrupt !== 4'b0000) begin
            errors++; $display("FAIL basic_irq got %b want 0000", core_interrupt);
        end
        if (active_core !== 2'd3) begin
            errors++; $display("FAIL basic_active got %0d want 3", active_core);
        end
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready got %b want 1", sample_ready);
        end
    endtask

    task automatic test_timeout();
        int to0;
        strobe(4'b0000, 4'b0000, 4'b1111);
        resp_en = 4'b1011;
        for (int i = 0; i < 4; i++) start_cyc[i] = -1;
        to0 = to_cnt;
        send_sample(4'b1111);
        wait_frame(3000);
        checks += 6;
        if (to_cnt - to0 !== 1) begin
            errors++; $display("FAIL tmo_count got %0d want 1", to_cnt - to0);
        end
        if (to_cyc - start_cyc[2] !== 2048) begin
            errors++;
            $display("FAIL tmo_delay got %0d want 2048", to_cyc - start_cyc[2]);
        end
        if (start_cyc[3] <= to_cyc) begin
            errors++;
            $display("FAIL tmo_core3 got %0d want after %0d",
                     start_cyc[3], to_cyc);
        end
        if (core_status !== 4'b1011) begin
            errors++; $display("FAIL tmo_status got %b want 1011", core_status);
        end
        if (core_interrupt !== 4'b0100) begin
            errors++; $display("FAIL tmo_irq got %b want 0100", core_interrupt);
        end
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL tmo_q got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_stop_resume();
        strobe(4'b0000, 4'b0010, 4'b0010);
        checks += 2;
        if (core_status !== 4'b1001) begin
            errors++; $display("FAIL sr_status got %b want 1001", core_status);
        end
        if (core_interrupt !== 4'b0110) begin
            errors++; $display("FAIL sr_irq got %b want 0110", core_interrupt);
        end
        strobe(4'b0000, 4'b0000, 4'b0010);
        checks += 2;
        if (core_status !== 4'b1011) begin
            errors++; $display("FAIL res_status got %b want 1011", core_status);
        end
        if (core_interrupt !== 4'b0100) begin
            errors++; $display("FAIL res_irq got %b want 0100", core_interrupt);
        end
        strobe(4'b0001, 4'b0000, 4'b0001);
        checks++;
        if (core_status !== 4'b1010) begin
            errors++; $display("FAIL pr_status got %b want 1010", core_status);
        end
        strobe(4'b1000, 4'b1000, 4'b0000);
        checks += 2;
        if (core_status !== 4'b0010) begin
            errors++; $display("FAIL sp_status got %b want 0010", core_status);
        end
        if (core_interrupt !== 4'b1100) begin
            errors++; $display("FAIL sp_irq got %b want 1100", core_interrupt);
        end
    endtask

    task automatic test_idle_frame();
        int n0;
        apply_reset();
        n0 = start_cnt;
        send_sample(4'b0000);
        wait_frame(20);
        checks += 3;
        if (fd_cyc - t_acc !== 5) begin
            errors++; $display("FAIL idle_fd got %0d want 5", fd_cyc - t_acc);
        end
        if (start_cnt !== n0) begin
            errors++; $display("FAIL idle_start got %0d want 0", start_cnt - n0);
        end
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b want 1", sample_ready);
        end
    endtask

    task automatic test_overrun();
        int d0;
        apply_reset();
        strobe(4'b0000, 4'b0000, 4'b1111);
        resp_en  = 4'b1111;
        resp_dly = 1000;
        sb_en    = 1'b0;
        d0 = drop_cnt;
        @(negedge clk_100mhz);
        sample_valid = 1'b1;
        repeat (70000) @(negedge clk_100mhz);
        sample_valid = 1'b0;
        wait_frame(6000);
        sb_en    = 1'b1;
        resp_dly = 3;
        checks += 2;
        if (overrun_count !== 16'hFFFF) begin
            errors++; $display("FAIL ovr_sat got %h want ffff", overrun_count);
        end
        if (drop_cnt - d0 < 65535) begin
            errors++;
            $display("FAIL ovr_pulses got %0d want >= 65535", drop_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n0;
        apply_reset();
        strobe(4'b0000, 4'b0000, 4'b0001);
        resp_en = 4'b0000;
        n0 = start_cnt;
        send_sample(4'b0001);
        repeat (5) @(negedge clk_100mhz);
        checks++;
        if (start_cnt - n0 !== 1) begin
            errors++; $display("FAIL mid_start got %0d want 1", start_cnt - n0);
        end
        @(posedge clk_100mhz);
        #2;
        resetn = 1'b0;
        #1;
        checks += 6;
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL mid_ready got %b want 1", sample_ready);
        end
        if (core_status !== 4'b0000) begin
            errors++; $display("FAIL mid_status got %b want 0000", core_status);
        end
        if (core_interrupt !== 4'b0000) begin
            errors++; $display("FAIL mid_irq got %b want 0000", core_interrupt);
        end
        if (active_core !== 2'd0) begin
            errors++; $display("FAIL mid_active got %0d want 0", active_core);
        end
        if (core_start !== 4'b0000) begin
            errors++; $display("FAIL mid_cstart got %b want 0000", core_start);
        end
        if (frame_timeout !== 1'b0) begin
            errors++; $display("FAIL mid_tmo got %b want 0", frame_timeout);
        end
        exp_q.delete();
        @(negedge clk_100mhz);
        resetn = 1'b1;
        n0 = start_cnt;
        repeat (20) @(negedge clk_100mhz);
        checks++;
        if (start_cnt !== n0) begin
            errors++;
            $display("FAIL mid_reissue got %0d want 0", start_cnt - n0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_stop_resume();
        test_idle_frame();
        test_overrun();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
